// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings and baud divider helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

    // Integer clock cycles per serial bit; shared with the transmitter.
    function automatic int cycles_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte delivery interface between the UART receiver and the fabric.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun_err;

    modport master (
        output rx_data, rx_valid, frame_err, overrun_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    // Metastability filter: d -> meta -> q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, valid/ready delivery, framing/overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     rx,
    uart_rx_if.master bus
);
    localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int COUNTER_WIDTH  = $clog2(CYCLES_PER_BIT);
    localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = COUNTER_WIDTH'(CYCLES_PER_BIT - 1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_HALF = COUNTER_WIDTH'(HALF_BIT - 1);

    logic                     rx_s;
    uart_state_e              state, state_nxt;
    logic [COUNTER_WIDTH-1:0] cnt;
    logic [2:0]               bit_idx;
    logic [7:0]               shift;
    logic [1:0]               settle;
    logic                     shift_en, stop_ok, stop_bad;
    logic                     deliver_pend;
    logic [7:0]               data_q;
    logic                     valid_q, ferr_q, oerr_q;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BREAK;
        else        state <= state_nxt;
    end

    // Next-state decode and sample strobes
    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE:  if (!rx_s) state_nxt = START;
            START: if (cnt == CNT_HALF) state_nxt = rx_s ? IDLE : DATA;
            DATA: begin
                if (cnt == CNT_LAST) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    if (rx_s) begin
                        stop_ok   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        stop_bad  = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            // The synchroniser resets to 1, so rx_s reads high for two cycles
            // after reset regardless of the line; leaving BREAK waits until that
            // reset value has been flushed so a held-low line is not mistaken
            // for idle followed by a start bit.
            BREAK: if (rx_s && settle == 2'd2) state_nxt = IDLE;
            default: state_nxt = BREAK;
        endcase
    end

    // Bit-time counter, bit index, shift register and post-reset settle count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            settle  <= 2'd0;
        end else begin
            if (state_nxt != state || shift_en) cnt <= '0;
            else                                cnt <= cnt + 1'b1;
            if (state == START)  bit_idx <= 3'd0;
            else if (shift_en)   bit_idx <= bit_idx + 3'd1;
            if (shift_en)        shift   <= {rx_s, shift[7:1]};
            if (settle != 2'd2)  settle  <= settle + 2'd1;
        end
    end

    // Output register: deliver, hold for handshake, or flag overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deliver_pend <= 1'b0;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            ferr_q       <= 1'b0;
            oerr_q       <= 1'b0;
        end else begin
            deliver_pend <= stop_ok;
            ferr_q       <= stop_bad;
            oerr_q       <= 1'b0;
            if (deliver_pend) begin
                if (!valid_q || bus.rx_ready) begin
                    data_q  <= shift;
                    valid_q <= 1'b1;
                end else begin
                    oerr_q  <= 1'b1;
                end
            end else if (valid_q && bus.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.rx_data     = data_q;
    assign bus.rx_valid    = valid_q;
    assign bus.frame_err   = ferr_q;
    assign bus.overrun_err = oerr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clock cycles per bit.
module tb_uart_rx;
    import uart_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;

    uart_rx_if bus();

    uart_rx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Output event counters, sampled on the rising edge
    int         rises = 0, vcycles = 0, ferrs = 0, oerrs = 0;
    logic       vprev = 1'b0;
    logic [7:0] last_data = 8'h00;

    always @(posedge clk) begin
        vprev <= bus.rx_valid;
        if (bus.rx_valid && !vprev) begin
            rises     <= rises + 1;
            last_data <= bus.rx_data;
        end
        if (bus.rx_valid)    vcycles <= vcycles + 1;
        if (bus.frame_err)   ferrs   <= ferrs + 1;
        if (bus.overrun_err) oerrs   <= oerrs + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame, one line change per negedge; optional one-cycle rx_ready pulse
    // at cycle ready_at, and early abort at cycle stop_at.
    task automatic send(input logic [7:0] d, input logic stop_bit,
                        input int ready_at, input int stop_at);
        for (int c = 0; c < 100; c++) begin
            if (c == stop_at) return;
            if (c < 10)      rx = 1'b0;
            else if (c < 90) rx = d[(c / 10) - 1];
            else             rx = stop_bit;
            if (c == ready_at)                        bus.rx_ready = 1'b1;
            else if (ready_at >= 0 && c == ready_at + 1) bus.rx_ready = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data",  32'(bus.rx_data),     32'h00);
        check("rst_valid", 32'(bus.rx_valid),    32'h0);
        check("rst_ferr",  32'(bus.frame_err),   32'h0);
        check("rst_oerr",  32'(bus.overrun_err), 32'h0);
        check("rst_state", 32'(dut.state),       32'(BREAK));
        rst_n = 1'b1;
        idle(10);
        check("idle_after_rst", 32'(dut.state), 32'(IDLE));

        // good byte
        send(8'hA5, 1'b1, -1, 100);
        idle(20);
        check("a5_rises",   32'(rises),     32'd1);
        check("a5_vcycles", 32'(vcycles),   32'd1);
        check("a5_data",    32'(last_data), 32'hA5);
        check("a5_ferr",    32'(ferrs),     32'd0);
        check("a5_oerr",    32'(oerrs),     32'd0);

        // start glitch
        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(20);
        check("glitch_state", 32'(dut.state), 32'(IDLE));
        check("glitch_rises", 32'(rises),     32'd1);
        check("glitch_ferr",  32'(ferrs),     32'd0);
        send(8'h3C, 1'b1, -1, 100);
        idle(20);
        check("3c_rises", 32'(rises),     32'd2);
        check("3c_data",  32'(last_data), 32'h3C);

        // framing error, line returns high
        send(8'h55, 1'b0, -1, 100);
        idle(20);
        check("fe1_ferr",  32'(ferrs), 32'd1);
        check("fe1_rises", 32'(rises), 32'd2);

        // framing error, line held low afterwards
        send(8'h55, 1'b0, -1, 100);
        rx = 1'b0;
        repeat (50) @(negedge clk);
        check("fe2_ferr",  32'(ferrs),        32'd2);
        check("fe2_rises", 32'(rises),        32'd2);
        check("fe2_valid", 32'(bus.rx_valid), 32'h0);
        check("fe2_state", 32'(dut.state),    32'(BREAK));
        idle(20);
        check("fe2_release", 32'(dut.state), 32'(IDLE));
        send(8'h0F, 1'b1, -1, 100);
        idle(20);
        check("0f_rises", 32'(rises),     32'd3);
        check("0f_data",  32'(last_data), 32'h0F);
        check("0f_ferr",  32'(ferrs),     32'd2);

        // overrun with consumer stalled
        bus.rx_ready = 1'b0;
        send(8'h11, 1'b1, -1, 100);
        send(8'h22, 1'b1, -1, 100);
        idle(20);
        check("ovr_data",  32'(bus.rx_data),  32'h11);
        check("ovr_valid", 32'(bus.rx_valid), 32'h1);
        check("ovr_oerr",  32'(oerrs),        32'd1);
        check("ovr_rises", 32'(rises),        32'd4);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        check("ovr_drop", 32'(bus.rx_valid), 32'h0);

        // ready arrives exactly in the delivery cycle of the second byte
        bus.rx_ready = 1'b0;
        send(8'h11, 1'b1, -1, 100);
        send(8'h22, 1'b1, 98, 100);
        idle(20);
        check("swap_data",  32'(bus.rx_data),  32'h22);
        check("swap_valid", 32'(bus.rx_valid), 32'h1);
        check("swap_oerr",  32'(oerrs),        32'd1);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        check("swap_drop", 32'(bus.rx_valid), 32'h0);

        // reset during data bit 4, released with the line low
        send(8'hFF, 1'b1, -1, 55);
        rst_n = 1'b0;
        rx    = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_rst_data",  32'(bus.rx_data),     32'h00);
        check("mid_rst_valid", 32'(bus.rx_valid),    32'h0);
        check("mid_rst_ferr",  32'(bus.frame_err),   32'h0);
        check("mid_rst_oerr",  32'(bus.overrun_err), 32'h0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_state", 32'(dut.state), 32'(BREAK));
        check("post_rst_rises", 32'(rises),     32'd5);
        check("post_rst_ferr",  32'(ferrs),     32'd2);
        idle(20);
        send(8'h81, 1'b1, -1, 100);
        idle(20);
        check("81_rises", 32'(rises),       32'd6);
        check("81_data",  32'(bus.rx_data), 32'h81);
        check("81_ferr",  32'(ferrs),       32'd2);
        check("81_oerr",  32'(oerrs),       32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
